// File: rtl/twos_pkg.sv
// twos_pkg: shared types and helpers for the serial negation block.
// Holds the controller state encoding and the bit-counter sizing rule.
package twos_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Bits needed to count 0..width-1; never below one bit.
  function automatic int cnt_w(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

  // Most negative value of a width-bit two's-complement word.
  function automatic logic [31:0] min_neg(input int width);
    logic [31:0] v;
    v = '0;
    v[width-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/twos_serial_core.sv
// twos_serial_core: one-bit-per-cycle negation step.
// Passes bits through until the first 1, then inverts the rest.
module twos_serial_core (
  input  logic t_clk,
  input  logic r,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic bit_out
);

  logic seen_one_q;

  // Track whether a 1 has been processed in the current word.
  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      seen_one_q <= 1'b0;
    end else if (clr) begin
      seen_one_q <= 1'b0;
    end else if (en) begin
      seen_one_q <= seen_one_q | bit_in;
    end
  end

  // Copy until the first one, invert afterwards.
  assign bit_out = bit_in ^ seen_one_q;

endmodule

// File: rtl/twos_comp_seq.sv
// twos_comp_seq: bit-serial two's-complement negator with handshakes.
// Controller sequences the serial core, counts bits, assembles dout.
module twos_comp_seq
  import twos_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             t_clk,
  input  logic             r,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(min_neg(WIDTH));

  state_t state_q;
  state_t state_d;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] dout_q;
  logic             ovf_cap_q;
  logic             ovf_q;

  logic accept;
  logic step;
  logic last;
  logic done_hs;
  logic res_bit;

  assign accept  = (state_q == IDLE) && in_valid;
  assign step    = (state_q == SHIFT);
  assign last    = step && (cnt_q == LAST);
  assign done_hs = (state_q == HOLD) && out_ready;

  twos_serial_core u_core (
    .t_clk   (t_clk),
    .r       (r),
    .clr     (accept),
    .en      (step),
    .bit_in  (sreg_q[0]),
    .bit_out (res_bit)
  );

  // State register.
  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: accept, shift WIDTH bits, hold until consumed.
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == IDLE):  if (in_valid) state_d = SHIFT;
      (state_q == SHIFT): if (last)     state_d = HOLD;
      (state_q == HOLD):  if (done_hs)  state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (1'b1)
      (state_q == IDLE):  in_ready  = 1'b1;
      (state_q == SHIFT): busy      = 1'b1;
      (state_q == HOLD): begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default:            in_ready  = 1'b0;
    endcase
  end

  // Bit counter: cleared on accept, advances once per shifted bit.
  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      cnt_q <= '0;
    end else if (accept || last) begin
      cnt_q <= '0;
    end else if (step) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Operand shift register feeds the core LSB first.
  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      sreg_q <= '0;
    end else if (accept) begin
      sreg_q <= din;
    end else if (step) begin
      sreg_q <= {1'b0, sreg_q[WIDTH-1:1]};
    end
  end

  // Result bits enter at the MSB and walk down to their place.
  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      acc_q <= '0;
    end else if (accept) begin
      acc_q <= '0;
    end else if (step) begin
      acc_q <= {res_bit, acc_q[WIDTH-1:1]};
    end
  end

  // Overflow flag sampled from the operand as it is captured.
  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      ovf_cap_q <= 1'b0;
    end else if (accept) begin
      ovf_cap_q <= (din == MIN_NEG);
    end
  end

  // Published result updates only when the last bit lands.
  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      dout_q <= '0;
      ovf_q  <= 1'b0;
    end else if (last) begin
      dout_q <= {res_bit, acc_q[WIDTH-1:1]};
      ovf_q  <= ovf_cap_q;
    end
  end

  assign dout = dout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_twos_comp_seq.sv
// tb_twos_comp_seq: directed bench with a cycle model and scoreboard.
// Literal expectations pin the model on the key operands.
module tb_twos_comp_seq;

  localparam int W = 8;

  logic         t_clk = 1'b0;
  logic         r = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] din = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] dout;
  logic         ovf;
  logic         busy;

  int n_checks = 0;
  int n_errs = 0;
  bit started = 1'b0;

  always #5 t_clk = ~t_clk;

  twos_comp_seq #(.WIDTH(W)) dut (
    .t_clk     (t_clk),
    .r         (r),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .ovf       (ovf),
    .busy      (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: operand accepted when free, result is arithmetic
  // negation available W edges later, held until consumed.
  logic         m_busy = 1'b0;
  logic         m_valid = 1'b0;
  logic         m_ovf = 1'b0;
  logic [W-1:0] m_dout = '0;
  logic [W-1:0] m_op = '0;
  int           m_age = 0;

  always @(posedge t_clk or posedge r) begin
    if (r) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_dout  <= '0;
      m_ovf   <= 1'b0;
      m_age   <= 0;
    end else if (m_valid) begin
      if (out_ready) m_valid <= 1'b0;
    end else if (m_busy) begin
      m_age <= m_age + 1;
      if (m_age == W - 1) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b1;
        m_dout  <= W'(0) - m_op;
        m_ovf   <= (m_op == {1'b1, {(W-1){1'b0}}});
      end
    end else if (in_valid) begin
      m_busy <= 1'b1;
      m_op   <= din;
      m_age  <= 0;
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge t_clk) begin
    if (started && !r) begin
      chk("cyc_in_ready", in_ready, !(m_busy || m_valid));
      chk("cyc_busy", busy, m_busy || m_valid);
      chk("cyc_out_valid", out_valid, m_valid);
      chk("cyc_dout", dout, m_dout);
      chk("cyc_ovf", ovf, m_ovf);
    end
  end

  // One conversion: offer x, wait for result, stall, then consume.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] ed,
                       input logic eo, input int stall, input bit churn);
    int lat;
    @(negedge t_clk);
    in_valid = 1'b1;
    din = x;
    @(posedge t_clk);
    #1;
    chk("acc_busy", busy, 1);
    if (!churn) in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (churn) din = W'($urandom);
      @(posedge t_clk);
      #1;
      lat++;
    end
    chk("latency", lat, W);
    chk("res_dout", dout, ed);
    chk("res_ovf", ovf, eo);
    repeat (stall) begin
      @(posedge t_clk);
      #1;
      chk("stall_valid", out_valid, 1);
      chk("stall_dout", dout, ed);
    end
    out_ready = 1'b1;
    @(posedge t_clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("hs_out_valid", out_valid, 0);
    chk("hs_in_ready", in_ready, 1);
    chk("hs_busy", busy, 0);
  endtask

  initial begin
    int per;
    #1 r = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge t_clk);
    r = 1'b0;
    started = 1'b1;

    do_op(8'h05, 8'hFB, 1'b0, 0, 1'b0);
    do_op(8'h80, 8'h80, 1'b1, 0, 1'b0);
    do_op(8'h00, 8'h00, 1'b0, 0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 5, 1'b0);
    do_op(8'h7F, 8'h81, 1'b0, 1, 1'b0);

    // out_ready while idle must do nothing.
    @(negedge t_clk);
    out_ready = 1'b1;
    repeat (3) @(negedge t_clk);
    out_ready = 1'b0;

    // Reset in the third shift cycle discards the operand.
    @(negedge t_clk);
    in_valid = 1'b1;
    din = 8'h37;
    @(posedge t_clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge t_clk);
    #2 r = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    #1 r = 1'b0;
    do_op(8'h01, 8'hFF, 1'b0, 0, 1'b0);

    // in_valid held with changing din during conversion.
    do_op(8'h0C, 8'hF4, 1'b0, 2, 1'b1);

    // Back-to-back: in_valid and out_ready held high.
    @(negedge t_clk);
    din = 8'h33;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge t_clk);
    #1;
    per = 0;
    while (busy && per < 40) begin
      @(posedge t_clk);
      #1;
      per++;
    end
    while (!busy && per < 40) begin
      @(posedge t_clk);
      #1;
      per++;
    end
    chk("b2b_period_ok", (per >= W + 1) && (per < 40), 1);
    in_valid = 1'b0;
    repeat (W + 4) @(negedge t_clk);
    out_ready = 1'b0;
    chk("b2b_last_dout", dout, 8'hCD);

    repeat (3) @(negedge t_clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/twos_comp_seq.md
TWOS_COMP_SEQ -- requirements
Module: twos_comp_seq

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; legal range 2..32.
REQ-002 t_clk  input  1  single clock for the whole block; all state updates on its rising edge.
REQ-003 r  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  parallel operand offered on din.
REQ-005 in_ready  output  1  block can accept an operand; high only in IDLE.
REQ-006 din  input  WIDTH  operand, two's-complement, LSB processed first.
REQ-007 out_valid  output  1  dout/ovf hold a completed result.
REQ-008 out_ready  input  1  consumer accepts the result.
REQ-009 dout  output  WIDTH  two's complement (negation) of the accepted operand.
REQ-010 ovf  output  1  accepted operand was the most negative value (1 followed by WIDTH-1 zeros).
REQ-011 busy  output  1  high in SHIFT or HOLD.

Function
REQ-012 FSM states IDLE, SHIFT, HOLD; only these three are reachable.
REQ-013 IDLE: in_ready=1; on in_valid=1 at a rising edge, capture din into the shift register, clear bit counter and seen_one flag, go to SHIFT.
REQ-014 SHIFT: one bit per cycle, LSB first; result bit = bit XOR seen_one; seen_one is set after any processed bit equal to 1 (copy-until-first-one, then invert).
REQ-015 The bit-serial negation step is performed by the sub-module of REQ-028; the controller only sequences it, counts bits and assembles dout.
REQ-016 Bit counter runs 0..WIDTH-1; on the edge that processes bit WIDTH-1, go to HOLD and assert out_valid.
REQ-017 Latency: out_valid is high exactly WIDTH rising edges after the accepting edge.
REQ-018 HOLD: dout, ovf and out_valid stay stable until out_valid && out_ready at an edge, then go to IDLE.
REQ-019 No same-edge turnaround: an operand cannot be accepted on the edge that completes the output handshake; in_ready rises the cycle after.
REQ-020 in_valid while busy=1 is ignored; din changes during SHIFT do not affect the result.
REQ-021 ovf = 1 iff the captured operand equals 1 followed by WIDTH-1 zeros; dout then equals the operand.
REQ-022 Zero operand yields dout=0, ovf=0.
REQ-023 out_ready while out_valid=0 has no effect.

Reset
REQ-024 r=1 forces IDLE immediately, independent of t_clk, including mid-SHIFT or in HOLD; an in-flight operand is discarded.
REQ-025 Reset values: in_ready=1, out_valid=0, busy=0, dout=0, ovf=0, bit counter=0, seen_one=0.
REQ-026 After r deasserts, the first rising edge with in_valid=1 is accepted normally.

Structure
REQ-027 Shared package twos_pkg holds the FSM state typedef (IDLE, SHIFT, HOLD) and the counter-width constant/function derived from WIDTH.
REQ-028 One sub-module, twos_serial_core: 1-bit in, 1-bit out, start-of-word clear, seen_one flop, same t_clk and r.
REQ-029 Controller (FSM, counter, shift/assemble registers, handshake) stays in twos_comp_seq.

Verification
REQ-030 WIDTH=8, din=8'h05 accepted -> after 8 edges out_valid=1, dout=8'hFB, ovf=0.
REQ-031 din=8'h80 -> dout=8'h80, ovf=1; din=8'h00 -> dout=8'h00, ovf=0; din=8'hFF -> dout=8'h01, ovf=0.
REQ-032 Result with out_ready=0 for 5 cycles -> dout/out_valid unchanged; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-033 r pulsed high at 3rd SHIFT cycle -> immediate IDLE, out_valid=0, dout=0; next operand 8'h01 -> dout=8'hFF.
REQ-034 in_valid held high with changing din throughout a conversion of 8'h0C -> only 8'h0C processed, dout=8'hF4; back-to-back operands each take WIDTH+1 cycles minimum.
